// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID->EX pipeline register slice.
// Holds the opcode constants the stage inspects, the default datapath and
// register-index widths, and the stage state encoding.
package id_ex_stage_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } stageState_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded fields from ID, pipeline control
// (flush, ex_stall, id_stall) and the registered EX-side copies.
// master : the surrounding core (drives id_*, flush, ex_stall)
// slave  : the id_ex_stage register slice (drives ex_*, id_stall)
interface id_ex_stage_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          id_valid;
  logic [4:0]    id_opcode;
  logic [1:0]    id_oper;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_reg_we;
  logic          id_mem_rd;
  logic          id_mem_wr;
  logic          flush;
  logic          ex_stall;
  logic          id_stall;
  logic          ex_valid;
  logic [4:0]    ex_opcode;
  logic [1:0]    ex_oper;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic          ex_reg_we;
  logic          ex_mem_rd;
  logic          ex_mem_wr;
  logic          ex_halt;

  modport master (
    output id_valid, id_opcode, id_oper, id_rs, id_rt, id_rd,
           id_uses_rs, id_uses_rt, id_rs_data, id_rt_data, id_imm,
           id_reg_we, id_mem_rd, id_mem_wr, flush, ex_stall,
    input  id_stall, ex_valid, ex_opcode, ex_oper, ex_rs, ex_rt, ex_rd,
           ex_rs_data, ex_rt_data, ex_imm, ex_reg_we, ex_mem_rd,
           ex_mem_wr, ex_halt
  );

  modport slave (
    input  id_valid, id_opcode, id_oper, id_rs, id_rt, id_rd,
           id_uses_rs, id_uses_rt, id_rs_data, id_rt_data, id_imm,
           id_reg_we, id_mem_rd, id_mem_wr, flush, ex_stall,
    output id_stall, ex_valid, ex_opcode, ex_oper, ex_rs, ex_rt, ex_rd,
           ex_rs_data, ex_rt_data, ex_imm, ex_reg_we, ex_mem_rd,
           ex_mem_wr, ex_halt
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Inputs : EX-slot valid/load/writeback/destination, ID-slot valid and
//          source-register usage/indices.
// Output : hazard - the ID instruction needs a register the load in EX
//          has not produced yet.
module hazard_detect #(
  parameter int RW = 3
) (
  input  logic          exValid,
  input  logic          exMemRd,
  input  logic          exRegWe,
  input  logic [RW-1:0] exRd,
  input  logic          idValid,
  input  logic          idUsesRs,
  input  logic          idUsesRt,
  input  logic [RW-1:0] idRs,
  input  logic [RW-1:0] idRt,
  output logic          hazard
);

  logic loadInExS;
  logic srcMatchS;

  assign loadInExS = exValid & exMemRd & exRegWe;
  assign srcMatchS = (idUsesRs & (idRs == exRd)) | (idUsesRt & (idRt == exRd));
  assign hazard    = loadInExS & idValid & srcMatchS;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use interlock and HALT freeze.
// Ports: clk, rst (synchronous, active high), bus (id_ex_stage_if.slave)
//   carrying decoded id_* fields, flush/ex_stall controls, the combinational
//   id_stall request and the registered ex_* copies including ex_halt.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  stageState_t   stateR, nextStateS;
  logic          hazardS;
  logic          captureS;
  logic          bubbleS;
  logic          idStallS;

  logic          exValidR;
  logic [4:0]    exOpcodeR;
  logic [1:0]    exOperR;
  logic [RW-1:0] exRsR, exRtR, exRdR;
  logic [DW-1:0] exRsDataR, exRtDataR, exImmR;
  logic          exRegWeR, exMemRdR, exMemWrR;

  hazard_detect #(.RW(RW)) uHazard (
    .exValid (exValidR),
    .exMemRd (exMemRdR),
    .exRegWe (exRegWeR),
    .exRd    (exRdR),
    .idValid (bus.id_valid),
    .idUsesRs(bus.id_uses_rs),
    .idUsesRt(bus.id_uses_rt),
    .idRs    (bus.id_rs),
    .idRt    (bus.id_rt),
    .hazard  (hazardS)
  );

  // Slot action for this edge: capture, load bubble, or hold (neither).
  // An invalid decode slot is loaded as a bubble so its controls are cleared.
  always_comb begin
    captureS = 1'b0;
    bubbleS  = 1'b0;
    if (stateR != RUN) begin
      captureS = 1'b0;
    end else if (bus.flush) begin
      bubbleS = 1'b1;
    end else if (bus.ex_stall) begin
      captureS = 1'b0;
    end else if (hazardS || !bus.id_valid) begin
      bubbleS = 1'b1;
    end else begin
      captureS = 1'b1;
    end
  end

  // Stall request to decode/fetch; once halted, flush no longer releases it.
  always_comb begin
    idStallS = 1'b0;
    if (stateR == HALTED) begin
      idStallS = 1'b1;
    end else if (bus.flush) begin
      idStallS = 1'b0;
    end else begin
      idStallS = hazardS | bus.ex_stall;
    end
  end

  // Next-state: a valid HALT entering EX freezes the stage until reset.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      RUN: begin
        if (captureS && (bus.id_opcode == OP_HALT)) begin
          nextStateS = HALTED;
        end else begin
          nextStateS = RUN;
        end
      end
      HALTED:  nextStateS = HALTED;
      default: nextStateS = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR <= RUN;
    end else begin
      stateR <= nextStateS;
    end
  end

  // EX slot registers: reset and bubble both load an invalid NOP with zeroed fields.
  always_ff @(posedge clk) begin
    if (rst || bubbleS) begin
      exValidR  <= 1'b0;
      exOpcodeR <= OP_NOP;
      exOperR   <= 2'b00;
      exRsR     <= {RW{1'b0}};
      exRtR     <= {RW{1'b0}};
      exRdR     <= {RW{1'b0}};
      exRsDataR <= {DW{1'b0}};
      exRtDataR <= {DW{1'b0}};
      exImmR    <= {DW{1'b0}};
      exRegWeR  <= 1'b0;
      exMemRdR  <= 1'b0;
      exMemWrR  <= 1'b0;
    end else if (captureS) begin
      exValidR  <= 1'b1;
      exOpcodeR <= bus.id_opcode;
      exOperR   <= bus.id_oper;
      exRsR     <= bus.id_rs;
      exRtR     <= bus.id_rt;
      exRdR     <= bus.id_rd;
      exRsDataR <= bus.id_rs_data;
      exRtDataR <= bus.id_rt_data;
      exImmR    <= bus.id_imm;
      exRegWeR  <= bus.id_reg_we;
      exMemRdR  <= bus.id_mem_rd;
      exMemWrR  <= bus.id_mem_wr;
    end
  end

  assign bus.id_stall   = idStallS;
  assign bus.ex_valid   = exValidR;
  assign bus.ex_opcode  = exOpcodeR;
  assign bus.ex_oper    = exOperR;
  assign bus.ex_rs      = exRsR;
  assign bus.ex_rt      = exRtR;
  assign bus.ex_rd      = exRdR;
  assign bus.ex_rs_data = exRsDataR;
  assign bus.ex_rt_data = exRtDataR;
  assign bus.ex_imm     = exImmR;
  assign bus.ex_reg_we  = exRegWeR;
  assign bus.ex_mem_rd  = exMemRdR;
  assign bus.ex_mem_wr  = exMemWrR;
  assign bus.ex_halt    = (stateR == HALTED);

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(16), .RW(3)) bus ();
  id_ex_stage #(.DW(16), .RW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vecs = 0;
  int errs = 0;

  // Reference model of the EX slot.
  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [1:0]  oper;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rsD, rtD, imm;
    logic        we, mrd, mwr;
  } slot_t;

  slot_t mSlot;
  bit    mHalted = 1'b0;
  bit    mReady  = 1'b0;

  function automatic slot_t emptySlot();
    slot_t s;
    s.valid = 1'b0; s.op = 5'd1; s.oper = 2'd0;
    s.rs = 3'd0; s.rt = 3'd0; s.rd = 3'd0;
    s.rsD = 16'd0; s.rtD = 16'd0; s.imm = 16'd0;
    s.we = 1'b0; s.mrd = 1'b0; s.mwr = 1'b0;
    return s;
  endfunction

  function automatic bit mHazard();
    bit needsLoad;
    needsLoad = (bus.id_uses_rs && bus.id_rs == mSlot.rd) ||
                (bus.id_uses_rt && bus.id_rt == mSlot.rd);
    return mSlot.valid && mSlot.mrd && mSlot.we && bus.id_valid && needsLoad;
  endfunction

  function automatic bit mStall();
    if (mHalted) return 1'b1;
    if (bus.flush) return 1'b0;
    return mHazard() || bus.ex_stall;
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic modelStep();
    if (rst) begin
      mSlot = emptySlot(); mHalted = 1'b0; mReady = 1'b1;
    end else if (mHalted || (!bus.flush && bus.ex_stall)) begin
      mSlot = mSlot;
    end else if (bus.flush || mHazard() || !bus.id_valid) begin
      mSlot = emptySlot();
    end else begin
      mSlot.valid = 1'b1;      mSlot.op = bus.id_opcode; mSlot.oper = bus.id_oper;
      mSlot.rs = bus.id_rs;    mSlot.rt = bus.id_rt;     mSlot.rd = bus.id_rd;
      mSlot.rsD = bus.id_rs_data; mSlot.rtD = bus.id_rt_data; mSlot.imm = bus.id_imm;
      mSlot.we = bus.id_reg_we; mSlot.mrd = bus.id_mem_rd; mSlot.mwr = bus.id_mem_wr;
      if (bus.id_opcode == 5'd0) mHalted = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    if (mReady) begin
      chk("ex_valid",   32'(bus.ex_valid),   32'(mSlot.valid));
      chk("ex_opcode",  32'(bus.ex_opcode),  32'(mSlot.op));
      chk("ex_oper",    32'(bus.ex_oper),    32'(mSlot.oper));
      chk("ex_rs",      32'(bus.ex_rs),      32'(mSlot.rs));
      chk("ex_rt",      32'(bus.ex_rt),      32'(mSlot.rt));
      chk("ex_rd",      32'(bus.ex_rd),      32'(mSlot.rd));
      chk("ex_rs_data", 32'(bus.ex_rs_data), 32'(mSlot.rsD));
      chk("ex_rt_data", 32'(bus.ex_rt_data), 32'(mSlot.rtD));
      chk("ex_imm",     32'(bus.ex_imm),     32'(mSlot.imm));
      chk("ex_reg_we",  32'(bus.ex_reg_we),  32'(mSlot.we));
      chk("ex_mem_rd",  32'(bus.ex_mem_rd),  32'(mSlot.mrd));
      chk("ex_mem_wr",  32'(bus.ex_mem_wr),  32'(mSlot.mwr));
      chk("ex_halt",    32'(bus.ex_halt),    32'(mHalted));
      chk("id_stall",   32'(bus.id_stall),   32'(mStall()));
    end
  endtask

  // One clock: check settled outputs, then take the edge and advance the model.
  task automatic step();
    #1;
    compareAll();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_opcode = 5'd1; bus.id_oper = 2'd0;
    bus.id_rs = 3'd0; bus.id_rt = 3'd0; bus.id_rd = 3'd0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_rs_data = 16'd0; bus.id_rt_data = 16'd0; bus.id_imm = 16'd0;
    bus.id_reg_we = 1'b0; bus.id_mem_rd = 1'b0; bus.id_mem_wr = 1'b0;
    bus.flush = 1'b0; bus.ex_stall = 1'b0;
  endtask

  task automatic presentLoad(input logic [2:0] rd);
    idle();
    bus.id_valid = 1'b1; bus.id_opcode = 5'b10001; bus.id_rd = rd;
    bus.id_rs = 3'd1; bus.id_reg_we = 1'b1; bus.id_mem_rd = 1'b1; bus.id_imm = 16'h0040;
  endtask

  task automatic presentAlu(input logic [2:0] rs, input logic usesRs);
    idle();
    bus.id_valid = 1'b1; bus.id_opcode = 5'b11011; bus.id_oper = 2'b01;
    bus.id_rs = rs; bus.id_uses_rs = usesRs; bus.id_rt = 3'd6; bus.id_rd = 3'd5;
    bus.id_rs_data = 16'h1234; bus.id_rt_data = 16'h0F0F; bus.id_reg_we = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("reset ex_opcode", 32'(bus.ex_opcode), 32'd1);
    chk("reset ex_halt",   32'(bus.ex_halt),   32'd0);

    // Basic capture
    presentAlu(3'd2, 1'b1);
    step();
    chk("cap ex_valid",   32'(bus.ex_valid),   32'd1);
    chk("cap ex_opcode",  32'(bus.ex_opcode),  32'h1B);
    chk("cap ex_oper",    32'(bus.ex_oper),    32'd1);
    chk("cap ex_rs_data", 32'(bus.ex_rs_data), 32'h1234);

    // Load-use: one-cycle stall, then the same instruction is captured
    presentLoad(3'd3);
    step();
    presentAlu(3'd3, 1'b1);
    #1;
    chk("lu id_stall", 32'(bus.id_stall), 32'd1);
    step();
    chk("lu bubble ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu released id_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("lu retry ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu retry ex_rs",    32'(bus.ex_rs),    32'd3);

    // No false hazard: source not used, then different register
    presentLoad(3'd3);
    step();
    presentAlu(3'd3, 1'b0);
    #1;
    chk("nouse id_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("nouse ex_valid", 32'(bus.ex_valid), 32'd1);
    presentLoad(3'd3);
    step();
    presentAlu(3'd4, 1'b1);
    #1;
    chk("diffreg id_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("diffreg ex_rs", 32'(bus.ex_rs), 32'd4);

    // Flush beats hazard and ex_stall
    presentLoad(3'd3);
    step();
    presentAlu(3'd3, 1'b1);
    bus.ex_stall = 1'b1; bus.flush = 1'b1;
    #1;
    chk("flush id_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("flush ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("flush ex_reg_we", 32'(bus.ex_reg_we), 32'd0);

    // ex_stall hold for 3 cycles with changing inputs
    idle();
    bus.id_valid = 1'b1; bus.id_opcode = 5'b00110; bus.id_rs_data = 16'hAAAA; bus.id_rd = 3'd2;
    step();
    for (int i = 0; i < 3; i++) begin
      presentAlu(3'(i), 1'b1);
      bus.id_rs_data = 16'(16'h5000 + i);
      bus.ex_stall = 1'b1;
      #1;
      chk("hold id_stall",   32'(bus.id_stall),   32'd1);
      chk("hold ex_opcode",  32'(bus.ex_opcode),  32'h06);
      chk("hold ex_rs_data", 32'(bus.ex_rs_data), 32'hAAAA);
      step();
    end
    idle();
    step();

    // HALT freezes everything until reset
    idle();
    bus.id_valid = 1'b1; bus.id_opcode = 5'b00000; bus.id_imm = 16'h0BAD;
    step();
    chk("halt ex_halt",  32'(bus.ex_halt),  32'd1);
    chk("halt id_stall", 32'(bus.id_stall), 32'd1);
    for (int i = 0; i < 10; i++) begin
      presentAlu(3'(i), 1'b1);
      bus.id_imm = 16'($urandom_range(0, 65535));
      bus.flush = 1'(i % 2);
      step();
      chk("halted ex_imm",    32'(bus.ex_imm),    32'h0BAD);
      chk("halted ex_opcode", 32'(bus.ex_opcode), 32'd0);
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-rst ex_halt",  32'(bus.ex_halt),  32'd0);
    chk("post-rst ex_valid", 32'(bus.ex_valid), 32'd0);

    // Invalid slot with HALT opcode must not halt
    idle();
    bus.id_valid = 1'b0; bus.id_opcode = 5'b00000;
    step();
    chk("inv halt ex_halt", 32'(bus.ex_halt), 32'd0);
    presentAlu(3'd1, 1'b1);
    step();
    chk("inv halt then cap", 32'(bus.ex_valid), 32'd1);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
